pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter stage: the next generation of the fetch-address generator.
- Holds the current fetch PC and produces the combinational next PC.
- Adds configurable width, reset vector and byte-addressed step, stall hold, prioritised trap/branch redirect, misaligned-target detection, and a sequential-advance counter.
- Sits at the head of the fetch pipeline and drives the instruction-memory address.

Parameters:
- XLEN, 32, width of pc and next_pc in bits.
- RESET_VECTOR, 32'h0000_0000, pc value loaded on reset.
- STEP, 4, byte increment for a sequential advance.
- CNT_W, 32, width of adv_count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- stall  in  1  hold pc (no sequential advance).
- branch_valid  in  1  branch/jump redirect request this cycle.
- branch_target  in  XLEN  branch/jump destination.
- trap_valid  in  1  trap redirect request this cycle.
- trap_vector  in  XLEN  trap handler address; low 2 bits forced to 0.
- is_compressed  in  1  current instruction is 16-bit; used only with PC_COMPRESSED_EN.
- next_pc  out  XLEN  combinational value pc will take at next edge.
- pc  out  XLEN  registered current fetch address.
- redirected  out  1  registered; 1 in the cycle after a taken redirect (flush hint).
- misalign_err  out  1  registered one-cycle pulse: branch rejected as misaligned.
- misalign_addr  out  XLEN  registered; last rejected branch target.
- adv_count  out  CNT_W  number of sequential advances since reset.

Behaviour:
- next_pc priority, combinational, first match wins:
  - reset_n=0 -> RESET_VECTOR.
  - trap_valid -> {trap_vector[XLEN-1:2],2'b00}.
  - branch_valid and target aligned -> branch_target.
  - branch_valid and target misaligned -> pc (hold).
  - stall -> pc.
  - otherwise -> pc + STEP.
- Aligned means target[1:0]==0. Under PC_COMPRESSED_EN, aligned means target[0]==0.
- pc <= next_pc every rising edge. There is no enable beyond the above.
- Arithmetic is modulo 2^XLEN. pc = 2^XLEN - STEP advances to 0 silently, with no flag.
- Redirects override stall: a trap or aligned branch with stall=1 still redirects.
- Trap and branch in the same cycle: trap wins, and no misalign_err is raised even if the branch target is misaligned.
- redirected <= 1 when a trap, or an aligned branch, was taken; else 0.
- Misaligned branch (no trap):
  - misalign_err <= 1 for exactly one cycle.
  - misalign_addr <= branch_target.
  - pc holds; redirected <= 0.
- Without a misaligned branch, misalign_err <= 0 and misalign_addr holds.
- adv_count increments by 1 only on a sequential advance: no reset, no trap, no branch, stall=0. It wraps at 2^CNT_W. It does not increment on holds or redirects.
- Reset is synchronous: on an edge with reset_n=0, all registered outputs take their reset values regardless of other inputs.
  - pc=RESET_VECTOR, redirected=0, misalign_err=0, misalign_addr=0, adv_count=0.
- Reset asserted mid-stall or mid-redirect discards the request.
- Deasserting reset_n: the first edge with reset_n=1 applies normal priority from pc=RESET_VECTOR.
- Latency: requests sampled at edge N are visible on pc after edge N. next_pc reflects them in the same cycle.

Optional Feature:
- Macro PC_COMPRESSED_EN.
- When defined:
  - Sequential step = 2 when is_compressed=1, else STEP.
  - Alignment granule is 2 bytes; branch_target[1:0]=2'b10 is legal.
  - trap_vector is still forced 4-byte aligned.
- When undefined:
  - is_compressed is ignored; step is always STEP.
  - Any target with [1:0]!=0 is misaligned.
  - Port list is unchanged.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with RESET_VECTOR=32'h100 -> pc=32'h100, adv_count=0, all flags 0. Release -> pc sequence 0x104, 0x108, 0x10C; adv_count 1, 2, 3.
- Stall: stall=1 for 3 cycles at pc=0x20 -> pc stays 0x20 and adv_count is frozen. Release -> pc 0x24.
- Priority: trap_valid with vector 0x803, plus branch_valid with target 0x41 and stall=1, same cycle -> pc=0x800, redirected=1 next cycle, misalign_err=0.
- Misaligned branch: branch to 0x42 at pc=0x10, macro off -> pc stays 0x10, misalign_err pulses once, misalign_addr=0x42. Same stimulus with macro on -> pc=0x42, no error.
- Wrap: pc=32'hFFFF_FFFC, no stall -> pc=0. Compressed, macro on: pc=0x10 with is_compressed=1 -> 0x12.
- Reset mid-redirect: reset_n=0 coincident with branch_valid to 0x200 -> pc=RESET_VECTOR, redirected=0.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch program counter with stall hold, prioritised trap/branch redirect,
// misaligned-branch rejection and a sequential-advance counter. Optional build macro: PC_COMPRESSED_EN.
module pc_unit #(
   parameter int unsigned            XLEN         = 32,
   parameter logic [XLEN-1:0]        RESET_VECTOR = '0,
   parameter int unsigned            STEP         = 4,
   parameter int unsigned            CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall,
   input  logic             branch_valid,
   input  logic [XLEN-1:0]  branch_target,
   input  logic             trap_valid,
   input  logic [XLEN-1:0]  trap_vector,
   input  logic             is_compressed,
   output logic [XLEN-1:0]  next_pc,
   output logic [XLEN-1:0]  pc,
   output logic             redirected,
   output logic             misalign_err,
   output logic [XLEN-1:0]  misalign_addr,
   output logic [CNT_W-1:0] adv_count
);

   localparam logic [XLEN-1:0] STEP_X = XLEN'(STEP);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic             redir_q, redir_d;
   logic             err_q, err_d;
   logic [XLEN-1:0]  maddr_q, maddr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [XLEN-1:0]  trap_tgt;
   logic [XLEN-1:0]  seq_step;
   logic             tgt_aligned;
   logic             unused_ok;

   // Trap handlers are always word aligned, even with compressed fetch.
   assign trap_tgt = {trap_vector[XLEN-1:2], 2'b00};

`ifdef PC_COMPRESSED_EN
   assign seq_step    = is_compressed ? XLEN'(2) : STEP_X;
   assign tgt_aligned = ~branch_target[0];
   assign unused_ok   = ^trap_vector[1:0];
`else
   assign seq_step    = STEP_X;
   assign tgt_aligned = (branch_target[1:0] == 2'b00);
   assign unused_ok   = ^{is_compressed, trap_vector[1:0]};
`endif

   always_comb begin
      pc_d    = pc_q;
      redir_d = 1'b0;
      err_d   = 1'b0;
      maddr_d = maddr_q;
      cnt_d   = cnt_q;
      if (!reset_n) begin
         pc_d    = RESET_VECTOR;
         maddr_d = '0;
         cnt_d   = '0;
      end else if (trap_valid) begin
         pc_d    = trap_tgt;
         redir_d = 1'b1;
      end else if (branch_valid) begin
         if (tgt_aligned) begin
            pc_d    = branch_target;
            redir_d = 1'b1;
         end else begin
            err_d   = 1'b1;
            maddr_d = branch_target;
         end
      end else if (!stall) begin
         pc_d  = pc_q + seq_step;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q    <= RESET_VECTOR;
         redir_q <= 1'b0;
         err_q   <= 1'b0;
         maddr_q <= '0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         redir_q <= redir_d;
         err_q   <= err_d;
         maddr_q <= maddr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign next_pc       = pc_d;
   assign pc            = pc_q;
   assign redirected    = redir_q;
   assign misalign_err  = err_q;
   assign misalign_addr = maddr_q;
   assign adv_count     = cnt_q;

endmodule
